// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } sar_state_t;

    localparam int SAR_WIDTH = 8;
    localparam int SAR_PTR_W = $clog2(SAR_WIDTH);

    // Pointer width for a given operand width, never narrower than one bit.
    function automatic int ptr_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sar_bitptr.sv
// Bit pointer for the search: counts down from the MSB index toward bit 0
// and decodes the current position into a one-hot mask.
module sar_bitptr
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [WIDTH-1:0] mask,
    output logic             last
);

    localparam int            PW    = ptr_width(WIDTH);
    localparam logic [PW-1:0] K_TOP = PW'(WIDTH - 1);

    logic [PW-1:0] k;

    // Reload to the MSB between searches, step down one bit per tested bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= K_TOP;
        end else if (load) begin
            k <= K_TOP;
        end else if (dec && (k != '0)) begin
            k <= k - PW'(1);
        end
    end

    assign mask = WIDTH'(1) << k;
    assign last = (k == '0);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller driving the threshold of an external
// unsigned >= comparator and binary-searching the largest TRIAL it accepts.
// Optional macro SAR_GE_PIPE_EN: the comparator result is registered
// externally, so each bit gets a WAIT cycle before GE is sampled in TEST.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             START,
    input  logic             GE,
    output logic [WIDTH-1:0] TRIAL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

    sar_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mask;
    logic             last;
    logic             ptr_load;
    logic             ptr_dec;

    assign ptr_load = (state == IDLE) || (state == FIN);
    assign ptr_dec  = (state == TEST);

    sar_bitptr #(
        .WIDTH (WIDTH)
    ) u_bitptr (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .load  (ptr_load),
        .dec   (ptr_dec),
        .mask  (mask),
        .last  (last)
    );

    assign acc_next = GE ? (acc | mask) : acc;

    // Search sequencer: every output is registered so TRIAL is stable for the whole cycle.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state  <= IDLE;
            acc    <= '0;
            TRIAL  <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    TRIAL <= '0;
                    BUSY  <= 1'b0;
                    if (START) begin
                        acc    <= '0;
                        RESULT <= '0;
                        TRIAL  <= MSB_BIT;
                        BUSY   <= 1'b1;
`ifdef SAR_GE_PIPE_EN
                        state  <= WAIT;
`else
                        state  <= TEST;
`endif
                    end
                end
`ifdef SAR_GE_PIPE_EN
                WAIT: begin
                    state <= TEST;
                end
`endif
                TEST: begin
                    acc <= acc_next;
                    if (last) begin
                        TRIAL  <= '0;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= acc_next;
                        state  <= FIN;
                    end else begin
                        TRIAL <= acc_next | (mask >> 1);
`ifdef SAR_GE_PIPE_EN
                        state <= WAIT;
`else
                        state <= TEST;
`endif
                    end
                end
                FIN: begin
                    TRIAL <= '0;
                    state <= IDLE;
                end
                default: begin
                    TRIAL <= '0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: behavioural comparator, position-based
// reference model checked every cycle, plus directed literal expectations.
`timescale 1ns/100ps
module tb_sar_search;
    import sar_pkg::*;

    localparam int W = SAR_WIDTH;
`ifdef SAR_GE_PIPE_EN
    localparam int REP     = 2;
    localparam int LAT     = 17;
    localparam int SPACING = 18;
`else
    localparam int REP     = 1;
    localparam int LAT     = 9;
    localparam int SPACING = 10;
`endif
    localparam int STEPS = W * REP;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ge;
    logic [W-1:0] target = '0;
    logic [W-1:0] trial;
    logic [W-1:0] result;
    logic         busy;
    logic         done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    logic [W-1:0] seen_trials[$];
    int           last_latency;
    logic [W-1:0] last_result;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle counter used for spacing measurements.
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural comparator, optionally registered.
`ifdef SAR_GE_PIPE_EN
    logic ge_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ge_q <= 1'b0;
        else        ge_q <= (target >= trial);
    end
    assign ge = ge_q;
`else
    assign ge = (target >= trial);
`endif

    sar_search #(
        .WIDTH (W)
    ) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .START       (start),
        .GE          (ge),
        .TRIAL       (trial),
        .BUSY        (busy),
        .DONE        (done),
        .RESULT      (result)
    );

    // Threshold for search step s: target bits above the tested bit, plus the tested bit.
    function automatic logic [W-1:0] expected_trial(input logic [W-1:0] t, input int step);
        int b;
        int upper;
        b     = W - 1 - step;
        upper = (int'(t) >> (b + 1)) << (b + 1);
        return W'(upper | (1 << b));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pos = -1 idle, 0..STEPS-1 searching, STEPS = done cycle.
    int           pos = -1;
    logic [W-1:0] cur_target = '0;
    logic [W-1:0] exp_result = '0;

    // Model advance at each clock edge, aborted asynchronously by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= -1;
            exp_result <= '0;
        end else if (pos < 0) begin
            if (start) begin
                pos        <= 0;
                cur_target <= target;
                exp_result <= '0;
            end
        end else if (pos == STEPS) begin
            pos <= -1;
        end else begin
            pos <= pos + 1;
            if (pos + 1 == STEPS) exp_result <= cur_target;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pos < 0) begin
                checkOutput("idle_trial", trial, 0);
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_done", done, 0);
                checkOutput("idle_result", result, exp_result);
            end else if (pos < STEPS) begin
                checkOutput("search_trial", trial, expected_trial(cur_target, pos / REP));
                checkOutput("search_busy", busy, 1);
                checkOutput("search_done", done, 0);
                checkOutput("search_result", result, 0);
            end else begin
                checkOutput("fin_trial", trial, 0);
                checkOutput("fin_busy", busy, 0);
                checkOutput("fin_done", done, 1);
                checkOutput("fin_result", result, exp_result);
            end
        end
    end

    // Pulse START for one cycle with the given target.
    task automatic applyStimulus(input logic [W-1:0] t);
        @(negedge clk);
        #1;
        target = t;
        start  = 1'b1;
    endtask

    // Run one search, optionally re-pulsing START after edges ra and rb.
    task automatic runSearch(input logic [W-1:0] t, input int ra, input int rb);
        int edges;
        seen_trials.delete();
        last_latency = -1;
        applyStimulus(t);
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0;
        while (edges < 60) begin
            @(negedge clk);
            if (busy) seen_trials.push_back(trial);
            if (done) begin
                last_latency = edges;
                last_result  = result;
                break;
            end
            #1;
            start = (edges == ra) || (edges == rb);
            @(posedge clk);
            edges++;
        end
        start = 1'b0;
        checkOutput("done_seen_in_budget", (last_latency > 0), 1);
    endtask

    // Watchdog against a hung bench.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] lit_a5 [8];
        int         dones;
        int         done_cycle [2];
        logic [W-1:0] done_res [2];

        lit_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_trial", trial, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Worked example 0xA5.
        runSearch(8'hA5, -1, -1);
        checkOutput("a5_latency", last_latency, LAT);
        checkOutput("a5_result", last_result, 8'hA5);
        checkOutput("a5_busy_cycles", seen_trials.size(), STEPS);
        if (seen_trials.size() == STEPS) begin
            for (int i = 0; i < 8; i++) begin
                for (int r = 0; r < REP; r++) begin
                    checkOutput("a5_trial_seq", seen_trials[i*REP + r], lit_a5[i]);
                end
            end
        end
        repeat (2) @(negedge clk);

        // Boundary targets.
        runSearch(8'h00, -1, -1);
        checkOutput("zero_result", last_result, 8'h00);
        if (seen_trials.size() == STEPS) begin
            checkOutput("zero_first_trial", seen_trials[0], 8'h80);
            checkOutput("zero_second_trial", seen_trials[REP], 8'h40);
            checkOutput("zero_last_trial", seen_trials[STEPS-1], 8'h01);
        end
        runSearch(8'hFF, -1, -1);
        checkOutput("ff_result", last_result, 8'hFF);
        if (seen_trials.size() == STEPS) begin
            checkOutput("ff_second_trial", seen_trials[REP], 8'hC0);
            checkOutput("ff_last_trial", seen_trials[STEPS-1], 8'hFF);
        end

        // START re-pulsed mid-search is ignored.
        runSearch(8'h3C, 3, 5);
        checkOutput("repulse_latency", last_latency, LAT);
        checkOutput("repulse_result", last_result, 8'h3C);
        repeat (2) @(negedge clk);

        // Asynchronous reset while testing bit 3.
        applyStimulus(8'h5A);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4 * REP) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        checkOutput("abort_trial", trial, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        #0.5;
        rst_n = 1'b1;
        dones = 0;
        repeat (STEPS + 4) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        runSearch(8'h5A, -1, -1);
        checkOutput("after_abort_result", last_result, 8'h5A);
        repeat (2) @(negedge clk);

        // START held high: back-to-back searches.
        dones = 0;
        @(negedge clk);
        #1;
        target = 8'h12;
        start  = 1'b1;
        for (int c = 0; c < 60 && dones < 2; c++) begin
            @(negedge clk);
            if (done) begin
                done_cycle[dones] = cycle;
                done_res[dones]   = result;
                dones++;
                #1;
                target = 8'hE7;
            end
        end
        #1;
        start = 1'b0;
        checkOutput("b2b_done_count", dones, 2);
        if (dones == 2) begin
            checkOutput("b2b_spacing", done_cycle[1] - done_cycle[0], SPACING);
            checkOutput("b2b_result0", done_res[0], 8'h12);
            checkOutput("b2b_result1", done_res[1], 8'hE7);
        end
        repeat (3) @(negedge clk);

        // Randomized targets with occasional ignored re-pulses.
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] t;
            int           ra;
            t  = W'($urandom_range(0, (1 << W) - 1));
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, STEPS - 1)) : -1;
            runSearch(t, ra, -1);
            checkOutput("rand_result", last_result, t);
            checkOutput("rand_latency", last_latency, LAT);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
